// File: rtl/pca_proj_sequencer.sv
// Time-multiplexed PCA projection: loads one feature vector, computes MIN_PC_NUM dot products
// with a single MAC against an external sync ROM, then streams results. Optional: PCA_ACC_SAT_EN.
module pca_proj_sequencer #(
    parameter int FP_SIZE    = 64,
    parameter int PC_NUM     = 32,
    parameter int MIN_PC_NUM = 5,
    localparam int NUM_COEF  = MIN_PC_NUM * PC_NUM,
    localparam int ADDR_W    = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1,
    localparam int IDX_W     = (MIN_PC_NUM > 1) ? $clog2(MIN_PC_NUM) : 1,
    localparam int ELEM_W    = (PC_NUM > 1) ? $clog2(PC_NUM) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               abort,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FP_SIZE-1:0] in_data,
    output logic [ADDR_W-1:0]  coef_addr,
    input  logic [FP_SIZE-1:0] coef_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FP_SIZE-1:0] out_data,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_last,
`ifdef PCA_ACC_SAT_EN
    output logic               sat_flag,
`endif
    output logic               busy
);

    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_OUTPUT  = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(NUM_COEF - 1);
    localparam logic [ELEM_W-1:0] LAST_J = ELEM_W'(PC_NUM - 1);
    localparam logic [IDX_W-1:0]  LAST_I = IDX_W'(MIN_PC_NUM - 1);

    logic [1:0]         state_reg;
    logic [ELEM_W-1:0]  load_cnt_reg;
    logic [ADDR_W-1:0]  k_reg;
    logic [IDX_W-1:0]   i_reg;
    logic [ELEM_W-1:0]  j_reg;
    logic               issue_done_reg;
    logic               d_valid_reg;
    logic [IDX_W-1:0]   d_i_reg;
    logic [ELEM_W-1:0]  d_j_reg;
    logic [FP_SIZE-1:0] acc_reg;
    logic [IDX_W-1:0]   out_idx_reg;
    logic [FP_SIZE-1:0] vec_reg [PC_NUM];
    logic [FP_SIZE-1:0] res_reg [MIN_PC_NUM];

    logic [FP_SIZE-1:0] vec_rd;
    logic [FP_SIZE-1:0] acc_base;
    logic [FP_SIZE-1:0] acc_next;
    logic               in_fire;
    logic               data_cycle;
    logic               row_end;
    logic               out_fire;

    assign in_ready   = (state_reg == ST_LOAD);
    assign busy       = (state_reg != ST_LOAD);
    assign out_valid  = (state_reg == ST_OUTPUT);
    assign out_idx    = out_idx_reg;
    assign out_last   = out_valid && (out_idx_reg == LAST_I);
    assign out_data   = out_valid ? res_reg[out_idx_reg] : '0;
    assign coef_addr  = k_reg;

    assign in_fire    = in_valid && in_ready && !abort;
    assign data_cycle = (state_reg == ST_COMPUTE) && d_valid_reg && !abort;
    assign row_end    = data_cycle && (d_j_reg == LAST_J);
    assign out_fire   = out_valid && out_ready && !abort;

    assign vec_rd   = vec_reg[d_j_reg];
    assign acc_base = (d_j_reg == '0) ? '0 : acc_reg;

`ifdef PCA_ACC_SAT_EN
    logic [2*FP_SIZE-1:0] prod_full;
    logic [2*FP_SIZE:0]   sum_full;
    logic                 row_sat;
    logic                 sat_reg;

    // Operands are non-negative, so once the accumulator pins at all-ones it stays there.
    always_comb begin
        prod_full = {{FP_SIZE{1'b0}}, vec_rd} * {{FP_SIZE{1'b0}}, coef_data};
        sum_full  = {1'b0, prod_full} + {{(FP_SIZE+1){1'b0}}, acc_base};
        row_sat   = (sum_full > {{(FP_SIZE+1){1'b0}}, {FP_SIZE{1'b1}}});
        acc_next  = row_sat ? {FP_SIZE{1'b1}} : sum_full[FP_SIZE-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_reg <= 1'b0;
        end else if (abort || (out_fire && out_last)) begin
            sat_reg <= 1'b0;
        end else if (data_cycle && row_sat) begin
            sat_reg <= 1'b1;
        end
    end

    assign sat_flag = sat_reg;
`else
    logic [FP_SIZE-1:0] prod_trunc;

    always_comb begin
        prod_trunc = vec_rd * coef_data;
        acc_next   = acc_base + prod_trunc;
    end
`endif

    generate
        for (genvar gi = 0; gi < PC_NUM; gi++) begin : g_vec
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vec_reg[gi] <= '0;
                end else if (in_fire && (load_cnt_reg == ELEM_W'(gi))) begin
                    vec_reg[gi] <= in_data;
                end
            end
        end

        for (genvar gi = 0; gi < MIN_PC_NUM; gi++) begin : g_res
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    res_reg[gi] <= '0;
                end else if (row_end && (d_i_reg == IDX_W'(gi))) begin
                    res_reg[gi] <= acc_next;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_LOAD;
            load_cnt_reg   <= '0;
            k_reg          <= '0;
            i_reg          <= '0;
            j_reg          <= '0;
            issue_done_reg <= 1'b0;
            d_valid_reg    <= 1'b0;
            d_i_reg        <= '0;
            d_j_reg        <= '0;
            acc_reg        <= '0;
            out_idx_reg    <= '0;
        end else if (abort) begin
            state_reg      <= ST_LOAD;
            load_cnt_reg   <= '0;
            k_reg          <= '0;
            i_reg          <= '0;
            j_reg          <= '0;
            issue_done_reg <= 1'b0;
            d_valid_reg    <= 1'b0;
            d_i_reg        <= '0;
            d_j_reg        <= '0;
            acc_reg        <= '0;
            out_idx_reg    <= '0;
        end else begin
            d_valid_reg <= 1'b0;
            case (state_reg)
                ST_LOAD: begin
                    if (in_fire) begin
                        if (load_cnt_reg == LAST_J) begin
                            load_cnt_reg <= '0;
                            state_reg    <= ST_COMPUTE;
                        end else begin
                            load_cnt_reg <= load_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    // Issue side runs one address ahead of the data side (ROM latency of 1).
                    if (!issue_done_reg) begin
                        d_valid_reg <= 1'b1;
                        d_i_reg     <= i_reg;
                        d_j_reg     <= j_reg;
                        if (k_reg == LAST_K) begin
                            issue_done_reg <= 1'b1;
                            k_reg          <= '0;
                            i_reg          <= '0;
                            j_reg          <= '0;
                        end else begin
                            k_reg <= k_reg + 1'b1;
                            if (j_reg == LAST_J) begin
                                j_reg <= '0;
                                i_reg <= i_reg + 1'b1;
                            end else begin
                                j_reg <= j_reg + 1'b1;
                            end
                        end
                    end
                    if (data_cycle) begin
                        acc_reg <= acc_next;
                        if (row_end && (d_i_reg == LAST_I)) begin
                            state_reg      <= ST_OUTPUT;
                            issue_done_reg <= 1'b0;
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (out_fire) begin
                        if (out_idx_reg == LAST_I) begin
                            out_idx_reg <= '0;
                            state_reg   <= ST_LOAD;
                        end else begin
                            out_idx_reg <= out_idx_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_pca_proj_sequencer.sv
// Directed bench for pca_proj_sequencer with FP_SIZE=16, PC_NUM=4, MIN_PC_NUM=2 and a model sync ROM.
module tb_pca_proj_sequencer;

    localparam int FP  = 16;
    localparam int PCN = 4;
    localparam int MIN = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [FP-1:0] in_data = '0;
    logic [2:0]    coef_addr;
    logic [FP-1:0] coef_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [FP-1:0] out_data;
    logic [0:0]    out_idx;
    logic          out_last;
    logic          busy;
`ifdef PCA_ACC_SAT_EN
    logic          sat_flag;
`endif

    logic [FP-1:0] rom [8];
    int checks = 0;
    int failures = 0;

    pca_proj_sequencer #(.FP_SIZE(FP), .PC_NUM(PCN), .MIN_PC_NUM(MIN)) dut (
        .clk(clk), .reset(reset), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last),
`ifdef PCA_ACC_SAT_EN
        .sat_flag(sat_flag),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) coef_data <= rom[coef_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rom_default();
        rom[0] = 16'd1; rom[1] = 16'd1; rom[2] = 16'd1; rom[3] = 16'd1;
        rom[4] = 16'd5; rom[5] = 16'd0; rom[6] = 16'd0; rom[7] = 16'd1;
    endtask

    // Streams four elements; returns #1 after the edge of the last handshake.
    task automatic send_vec(input logic [FP-1:0] a0, input logic [FP-1:0] a1,
                            input logic [FP-1:0] a2, input logic [FP-1:0] a3, input bit gap);
        logic [FP-1:0] v [4];
        int guard;
        v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
        for (int e = 0; e < 4; e++) begin
            if (gap && e > 0) begin
                in_valid = 1'b0;
                in_data  = 16'hDEAD;
                tick();
            end
            in_valid = 1'b1;
            in_data  = v[e];
            guard = 0;
            while (!in_ready && guard < 50) begin
                tick();
                guard++;
            end
            if (guard >= 50) check_eq("in_ready_timeout", 32'd0, 32'd1);
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
        $display("sent vector %0d %0d %0d %0d", a0, a1, a2, a3);
        check_eq("busy_after_load", busy, 1);
        check_eq("in_ready_after_load", in_ready, 0);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check_eq("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic recv(input logic [FP-1:0] e0, input logic [FP-1:0] e1, input int stall);
        int n;
        logic [FP-1:0] exp [2];
        exp[0] = e0; exp[1] = e1;
        wait_valid(n);
        for (int idx = 0; idx < 2; idx++) begin
            check_eq("out_valid", out_valid, 1);
            check_eq("out_data", out_data, exp[idx]);
            check_eq("out_idx", out_idx, idx);
            check_eq("out_last", out_last, (idx == 1) ? 1 : 0);
            if (idx == 0 && stall > 0) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    tick();
                    check_eq("stall_data", out_data, exp[0]);
                    check_eq("stall_idx", out_idx, 0);
                    check_eq("stall_in_ready", in_ready, 0);
                end
                out_ready = 1'b1;
            end
            $display("result idx=%0d data=0x%0h last=%0d", out_idx, out_data, out_last);
            tick();
        end
        check_eq("done_out_valid", out_valid, 0);
        check_eq("done_in_ready", in_ready, 1);
        check_eq("done_busy", busy, 0);
    endtask

    initial begin
        int n;
        rom_default();
        #12;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_idx", out_idx, 0);
        check_eq("rst_out_last", out_last, 0);
        check_eq("rst_coef_addr", coef_addr, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Basic pass with latency measured from the last input handshake cycle.
        send_vec(16'd1, 16'd2, 16'd3, 16'd4, 1'b0);
        wait_valid(n);
        check_eq("latency", n + 1, 10);
        recv(16'd10, 16'd9, 0);

        // Gapped input and output stall.
        send_vec(16'd1, 16'd2, 16'd3, 16'd4, 1'b1);
        recv(16'd10, 16'd9, 5);

        // Overflow: 0x8000 * 2 and 0x8000 * 5 both exceed 16 bits.
        rom[0] = 16'd2; rom[1] = 16'd2; rom[2] = 16'd2; rom[3] = 16'd2;
        send_vec(16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0);
`ifdef PCA_ACC_SAT_EN
        wait_valid(n);
        check_eq("sat_flag_set", sat_flag, 1);
        recv(16'hFFFF, 16'hFFFF, 0);
        check_eq("sat_flag_clear", sat_flag, 0);
`else
        recv(16'h0000, 16'h0000, 0);
`endif
        rom_default();

        // Abort at k=3, then a beat coinciding with abort must be dropped.
        send_vec(16'd7, 16'd7, 16'd7, 16'd7, 1'b0);
        tick(); tick(); tick();
        check_eq("abort_k3_addr", coef_addr, 3);
        abort = 1'b1;
        tick();
        check_eq("abort_in_ready", in_ready, 1);
        check_eq("abort_out_valid", out_valid, 0);
        check_eq("abort_busy", busy, 0);
        in_valid = 1'b1;
        in_data  = 16'd100;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        $display("abort issued");
        send_vec(16'd1, 16'd2, 16'd3, 16'd4, 1'b0);
        recv(16'd10, 16'd9, 0);

        // Asynchronous reset while idx0 is presented.
        out_ready = 1'b0;
        send_vec(16'd4, 16'd4, 16'd4, 16'd4, 1'b0);
        wait_valid(n);
        check_eq("pre_reset_valid", out_valid, 1);
        #1 reset = 1'b1;
        #1;
        check_eq("areset_out_valid", out_valid, 0);
        check_eq("areset_busy", busy, 0);
        check_eq("areset_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        $display("reset mid-output");
        send_vec(16'd1, 16'd2, 16'd3, 16'd4, 1'b0);
        recv(16'd10, 16'd9, 0);

        // Back-to-back vectors.
        send_vec(16'd1, 16'd2, 16'd3, 16'd4, 1'b0);
        recv(16'd10, 16'd9, 0);
        send_vec(16'd4, 16'd3, 16'd2, 16'd1, 1'b0);
        recv(16'd10, 16'd21, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
